// File: rtl/e_gpu_mem_pkg.sv
// Shared types and helpers for the e-GPU behavioural memories.
// Byte-merge helper is sized for the widest word any instance may use.
package e_gpu_mem_pkg;

  typedef enum logic {
    WRITE_FIRST,
    READ_FIRST
  } rdw_mode_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_e;

  localparam int MAX_DW  = 1024;
  localparam int MAX_BEW = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0]  old_w,
    input logic [MAX_DW-1:0]  new_w,
    input logic [MAX_BEW-1:0] be
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_BEW; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Clear sequencer: sweeps every word to zero, one word per cycle.
// Reset aborts a sweep; the write is suppressed in the reset cycle.
module mem_clear_ctrl
  import e_gpu_mem_pkg::*;
#(
  parameter int SIZE           = 64,
  parameter int ADDRW          = $clog2(SIZE),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  output logic             busy,
  output logic             clr_we,
  output logic [ADDRW-1:0] clr_addr
);

  localparam logic [ADDRW-1:0] LAST = ADDRW'(SIZE - 1);

  clr_state_e       state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;
  logic             auto_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      auto_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      auto_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clear_i || auto_q) begin
          state_d = CLR_SWEEP;
          cnt_d   = '0;
        end
      end
      CLR_SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDRW'(1);
        end
      end
    endcase
  end

  assign busy     = (state_q == CLR_SWEEP);
  assign clr_we   = busy & ~rst_i;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/multi_port_mem_behavioral.sv
// Behavioural 1W/NR memory with byte enables, RDW policy,
// optional registered read and a sweep-based clear.
module multi_port_mem_behavioral
  import e_gpu_mem_pkg::*;
#(
  parameter int        DATAW          = 32,
  parameter int        SIZE           = 64,
  parameter int        NUM_RPORTS     = 2,
  parameter bit        OUT_REG        = 1'b0,
  parameter rdw_mode_e RDW_MODE       = WRITE_FIRST,
  parameter bit        CLEAR_ON_RESET = 1'b1,
  parameter int        ADDRW          = $clog2(SIZE),
  parameter int        BEW            = DATAW / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  output logic                        busy_o,
  input  logic                        wren_i,
  input  logic [BEW-1:0]              wbe_i,
  input  logic [ADDRW-1:0]            waddr_i,
  input  logic [DATAW-1:0]            wdata_i,
  input  logic [NUM_RPORTS-1:0]       rden_i,
  input  logic [NUM_RPORTS*ADDRW-1:0] raddr_i,
  output logic [NUM_RPORTS*DATAW-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]       rvalid_o
);

  logic [DATAW-1:0] mem [SIZE];

  logic             busy;
  logic             clr_we;
  logic [ADDRW-1:0] clr_addr;
  logic             w_ok;
  logic [DATAW-1:0] w_old;
  logic [DATAW-1:0] w_new;

  function automatic logic in_range(input logic [ADDRW-1:0] a);
    return int'(a) < SIZE;
  endfunction

  mem_clear_ctrl #(
    .SIZE          (SIZE),
    .ADDRW         (ADDRW),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign busy_o = busy;

  assign w_ok  = wren_i & ~busy & ~rst_i
               & in_range(waddr_i);
  assign w_old = in_range(waddr_i)
               ? mem[waddr_i] : '0;
  assign w_new = DATAW'(be_merge(
                   MAX_DW'(w_old),
                   MAX_DW'(wdata_i),
                   MAX_BEW'(wbe_i)));

  // Clear sweep owns the write port while busy.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (w_ok) begin
      mem[waddr_i] <= w_new;
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [ADDRW-1:0] ra;
    logic [DATAW-1:0] arr_word;
    logic [DATAW-1:0] rd_word;
    logic             rd_en;

    assign ra       = raddr_i[p*ADDRW +: ADDRW];
    assign arr_word = in_range(ra) ? mem[ra] : '0;
    assign rd_en    = rden_i[p] & ~busy;

    if (RDW_MODE == WRITE_FIRST) begin : g_wf
      logic hit;
      assign hit     = w_ok & (ra == waddr_i);
      assign rd_word = hit ? w_new : arr_word;
    end else begin : g_rf
      assign rd_word = arr_word;
    end

    if (OUT_REG) begin : g_reg
      logic [DATAW-1:0] q;
      logic             v;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          q <= '0;
          v <= 1'b0;
        end else begin
          v <= rd_en;
          if (rd_en) q <= rd_word;
        end
      end
      assign rdata_o[p*DATAW +: DATAW] = q;
      assign rvalid_o[p]               = v;
    end else begin : g_comb
      assign rdata_o[p*DATAW +: DATAW] = rd_word;
      assign rvalid_o[p]               = rd_en;
    end
  end

endmodule

// File: tb/tb_multi_port_mem_behavioral.sv
// Bench for multi_port_mem_behavioral: two configurations share one
// stimulus stream and are checked against an array-level model.
module tb_multi_port_mem_behavioral;
  import e_gpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        wren = 1'b0;
  logic [3:0]  wbe = '0;
  logic [5:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  rden = '0;
  logic [11:0] raddr = '0;

  logic        busy_a, busy_b;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rvalid_a, rvalid_b;

  always #5 clk = ~clk;

  multi_port_mem_behavioral #(
    .DATAW(32), .SIZE(64), .NUM_RPORTS(2),
    .OUT_REG(1'b0), .RDW_MODE(WRITE_FIRST),
    .CLEAR_ON_RESET(1'b1)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .busy_o(busy_a), .wren_i(wren), .wbe_i(wbe),
    .waddr_i(waddr), .wdata_i(wdata),
    .rden_i(rden), .raddr_i(raddr),
    .rdata_o(rdata_a), .rvalid_o(rvalid_a)
  );

  multi_port_mem_behavioral #(
    .DATAW(32), .SIZE(48), .NUM_RPORTS(2),
    .OUT_REG(1'b1), .RDW_MODE(READ_FIRST),
    .CLEAR_ON_RESET(1'b0)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .busy_o(busy_b), .wren_i(wren), .wbe_i(wbe),
    .waddr_i(waddr), .wdata_i(wdata),
    .rden_i(rden), .raddr_i(raddr),
    .rdata_o(rdata_b), .rvalid_o(rvalid_b)
  );

  // Model: index 0 = u_a, index 1 = u_b.
  logic [31:0] mdl_mem [2][64];
  bit          mdl_known [2][64];
  int          sweep [2];
  bit          pend [2];
  int          sz [2];
  logic [31:0] dq [2];
  bit          vq [2];
  bit          dk [2];
  logic [31:0] fill_v [64];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] n,
                                        logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic check_outputs();
    logic [31:0] e;
    int a;
    chk("busy_a", 64'(busy_a), 64'(sweep[0] >= 0));
    chk("busy_b", 64'(busy_b), 64'(sweep[1] >= 0));
    for (int p = 0; p < 2; p++) begin
      a = int'(raddr[p*6 +: 6]);
      chk($sformatf("rvalid_a%0d", p), 64'(rvalid_a[p]),
          64'(rden[p] && sweep[0] < 0));
      if (rden[p] && sweep[0] < 0 && mdl_known[0][a]) begin
        e = mdl_mem[0][a];
        if (!rst && wren && int'(waddr) == a)
          e = merge(e, wdata, wbe);
        chk($sformatf("rdata_a%0d", p),
            64'(rdata_a[p*32 +: 32]), 64'(e));
      end
      chk($sformatf("rvalid_b%0d", p),
          64'(rvalid_b[p]), 64'(vq[p]));
      if (dk[p])
        chk($sformatf("rdata_b%0d", p),
            64'(rdata_b[p*32 +: 32]), 64'(dq[p]));
    end
  endtask

  task automatic update_models();
    int a;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        vq[p] = 0; dq[p] = '0; dk[p] = 1;
      end else if (rden[p] && sweep[1] < 0) begin
        vq[p] = 1;
        a = int'(raddr[p*6 +: 6]);
        if (a >= sz[1]) begin
          dq[p] = '0; dk[p] = 1;
        end else begin
          dq[p] = mdl_mem[1][a]; dk[p] = mdl_known[1][a];
        end
      end else begin
        vq[p] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sweep[i] = -1;
        pend[i]  = (i == 0);
      end else if (sweep[i] >= 0) begin
        mdl_mem[i][sweep[i]]   = '0;
        mdl_known[i][sweep[i]] = 1;
        sweep[i] = (sweep[i] == sz[i] - 1) ? -1 : sweep[i] + 1;
        pend[i]  = 0;
      end else begin
        a = int'(waddr);
        if (wren && a < sz[i]) begin
          mdl_mem[i][a] = merge(mdl_mem[i][a], wdata, wbe);
          if (wbe == 4'hF) mdl_known[i][a] = 1;
        end
        if (pend[i] || clear) sweep[i] = 0;
        pend[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_models();
    #1;
  endtask

  task automatic idle_in();
    rst = 0; clear = 0; wren = 0; rden = '0; wbe = '0;
  endtask

  task automatic rand_in();
    rst   = 0;
    wren  = 1'($urandom_range(0, 1));
    wbe   = 4'($urandom);
    waddr = 6'($urandom);
    wdata = $urandom;
    rden  = 2'($urandom);
    raddr = 12'($urandom);
    clear = ($urandom_range(0, 149) == 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_a || busy_b) && k < 300) begin
      step();
      k++;
    end
    chk("idle_wait", 64'(k < 300), 64'(1));
  endtask

  task automatic write_word(int a, logic [31:0] d,
                            logic [3:0] be);
    wren = 1; waddr = 6'(a); wdata = d; wbe = be;
    step();
    wren = 0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      raddr = {6'(2*i + 1), 6'(2*i)};
      rden  = 2'b11;
      step();
    end
    rden = '0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    sz[0] = 64; sz[1] = 48;
    sweep[0] = -1; sweep[1] = -1;
    pend[0] = 1; pend[1] = 0;
    for (int p = 0; p < 2; p++) begin
      vq[p] = 0; dq[p] = '0; dk[p] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    chk("rst_busy", 64'({busy_a, busy_b}), 64'(0));
    chk("rst_rvalid", 64'({rvalid_a, rvalid_b}), 64'(0));
    chk("rst_rdata_b", rdata_b, 64'(0));

    // Release reset: u_a auto-sweeps, u_b sweeps on clear.
    rst = 0; clear = 1;
    step();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (busy_a) n++;
      else if (n > 0) break;
      rand_in();
      clear = 0;
      step();
    end
    chk("sweep_len_a", 64'(n), 64'(64));
    idle_in();
    wait_idle();
    read_all();

    // Byte-enable merge.
    write_word(5, 32'hDEADBEEF, 4'hF);
    write_word(5, 32'h000000AA, 4'h1);
    raddr = 12'd5; rden = 2'b01;
    #1 chk("merge_a", 64'(rdata_a[31:0]), 64'h0DEADBEAA);
    step();
    rden = '0;
    #1 chk("merge_b", 64'(rdata_b[31:0]), 64'h0DEADBEAA);

    // Read during write.
    write_word(9, 32'h11111111, 4'hF);
    wren = 1; waddr = 6'd9; wdata = 32'h22222222;
    wbe = 4'b1100; raddr = 12'd9; rden = 2'b01;
    #1 chk("rdw_wf", 64'(rdata_a[31:0]), 64'h22221111);
    step();
    wren = 0; rden = '0;
    #1 chk("rdw_rf_old", 64'(rdata_b[31:0]), 64'h11111111);
    rden = 2'b01;
    step();
    rden = '0;
    #1 chk("rdw_rf_new", 64'(rdata_b[31:0]), 64'h22221111);

    // Both ports on one address, then hold.
    write_word(3, 32'hCAFEF00D, 4'hF);
    raddr = {6'd3, 6'd3}; rden = 2'b11;
    step();
    rden = '0;
    #1;
    chk("dual_v", 64'(rvalid_b), 64'(2'b11));
    chk("dual_d0", 64'(rdata_b[31:0]), 64'hCAFEF00D);
    chk("dual_d1", 64'(rdata_b[63:32]), 64'hCAFEF00D);
    step();
    #1;
    chk("hold_v", 64'(rvalid_b), 64'(0));
    chk("hold_d", rdata_b, {32'hCAFEF00D, 32'hCAFEF00D});

    // Clear in the middle of traffic, writes hammering.
    repeat (200) begin rand_in(); step(); end
    rand_in(); clear = 1;
    step();
    repeat (80) begin
      rand_in(); clear = 0; wren = 1;
      step();
    end
    idle_in();
    wait_idle();
    read_all();

    repeat (1500) begin rand_in(); step(); end
    idle_in();
    wait_idle();

    // Reset in sweep cycle 10.
    for (int i = 0; i < 64; i++) begin
      fill_v[i] = $urandom | 32'h1;
      write_word(i, fill_v[i], 4'hF);
    end
    clear = 1;
    step();
    clear = 0;
    repeat (10) step();
    rst = 1;
    step();
    rst = 0;
    #1 chk("abort_busy_b", 64'(busy_b), 64'(0));
    raddr = {6'd10, 6'd9}; rden = 2'b11;
    step();
    rden = '0;
    #1;
    chk("abort_w9", 64'(rdata_b[31:0]), 64'(0));
    chk("abort_w10", 64'(rdata_b[63:32]), 64'(fill_v[10]));
    read_all();
    wait_idle();
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
